pool_stream: RTL and testbench
==============================

// Module: pool_stream
// PURPOSE
//  Streaming multi-channel pooling stage placed between conv/relu outputs and the next conv layer.
//  Reduces each framed window of beats (s_first..s_last) to one output beat per window.
//  Max or average is selected per window; CHANNELS lanes are processed in parallel.
//  Both input and output use valid/ready handshakes.
// PARAMETERS
//  CHANNELS  6   number of parallel planes (lanes) per beat
//  DATA_W    16  signed sample width per lane
//  WIN_LOG2  2   log2 of the nominal window length (4 = 2x2 pool); average divisor = 2**WIN_LOG2
// PORTS
//  clk       in   1                 clock; all logic on rising edge
//  rst       in   1                 synchronous active-high reset
//  cfg_mode  in   1                 0 = max, 1 = average; sampled on the s_first beat only
//  s_valid   in   1                 input beat valid
//  s_ready   out  1                 input beat accepted when s_valid & s_ready
//  s_first   in   1                 first beat of a window
//  s_last    in   1                 last beat of a window
//  s_data    in   CHANNELS*DATA_W   lane i at [i*DATA_W +: DATA_W], signed
//  m_valid   out  1                 result valid; held until m_ready
//  m_ready   in   1                 downstream accepts result
//  m_data    out  CHANNELS*DATA_W   pooled result, same lane packing
//  err_frame out  1                 one-cycle pulse on a framing error
// BEHAVIOUR
//  Reset: all outputs are 0 except s_ready = 1. State goes to IDLE, and accumulators and the count clear.
//  FSM states:
//   - IDLE:  s_ready = 1.
//       - Accepted beat with s_first: load lanes, latch cfg_mode, set cnt = 1, go to ACCUM.
//       - Accepted beat without s_first: dropped, err_frame pulses, stay IDLE.
//   - ACCUM: s_ready = 1. Each accepted beat updates every lane and does cnt++ (saturating at 2**WIN_LOG2+1).
//       - max: lane = signed max(lane, d).
//       - avg: lane += sign-extended d in a DATA_W+WIN_LOG2+1 bit accumulator.
//       - Beat with s_first: the window restarts with this beat, the old partial window is discarded, err_frame pulses.
//       - Beat with s_last: result registered, go to HOLD.
//   - HOLD:  m_valid = 1 and m_data is stable; s_ready = m_ready.
//       - m_ready & accepted beat: processed as if in IDLE in the same cycle (zero-bubble back-to-back windows).
//       - m_ready & no beat: go to IDLE.
//  s_first & s_last on one beat: single-element window; result = d for max and for avg (no shift).
//  Latency: last beat accepted at cycle N -> m_valid high at N+1.
//  Avg result: accumulator >>> WIN_LOG2 (arithmetic, floor), then saturated to DATA_W signed range.
//  Avg count check: if cnt != 2**WIN_LOG2 at s_last (single-element windows excepted), result is still produced and err_frame pulses with it.
//  Max result: exact, no saturation needed.
//  Mid-window cfg_mode changes are ignored. Reset mid-window discards everything; no output.
//  Input-side valid/ready: data presented with s_valid low is ignored; no combinational path s_valid->s_ready.
// CONFIGURATION
//  POOL_FUSED_RELU_EN
//   - Defined: each lane of m_data is clamped to 0 when negative, applied after pooling and saturation, so relu merges into this stage.
//   - Undefined: m_data is passed signed and unmodified; no clamp logic is built.
// STRUCTURE
//  Package cnn_pkg:
//   - typedef enum logic {POOL_MAX, POOL_AVG} pool_mode_e
//   - typedef enum logic [1:0] {IDLE, ACCUM, HOLD} pool_state_e
//   - function sat_signed(value, width) shared with conv/acc saturation
//  Sub-module pool_lane: one lane with load/update/finalize controls, mode and the accumulator register.
//   - Instantiated CHANNELS times by generate.
//   - The top holds the FSM, the count, the handshake and err_frame.
// TESTING
//  1. max, 4 beats, lane0 = 3,-7,12,5, lane1 = -1,-2,-3,-4 -> one m_valid beat with lane0 = 12, lane1 = -1, at N+1.
//  2. avg, 4 beats, lane0 = 10,11,12,13 -> 11 (46>>>2); lane0 = -1,-1,-1,-2 -> -2 (floor).
//  3. avg, DATA_W=16, 4 beats of 32767 -> 32767; 4 beats of -32768 -> -32768; no wrap.
//  4. Hold m_ready = 0 for 5 cycles in HOLD -> m_data stable and s_ready = 0; then m_ready = 1 with the next s_first beat
//     -> both handshakes complete in the same cycle, and the next result follows with no bubble.
//  5. Framing: beat without s_first in IDLE -> err_frame pulse, no output.
//     - s_first mid-window -> pulse, and the restarted window's result excludes the old beats.
//     - 3-beat avg window -> result plus pulse.
//  6. Assert rst during beat 2 of a window, then send a fresh window -> only the fresh result appears.
//     With POOL_FUSED_RELU_EN, max of -5,-3 gives 0.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared CNN datapath types and helpers: pooling mode/state enums and the
// signed saturation helper used by the conv, accumulate and pool stages.
package cnn_pkg;

  typedef enum logic {
    POOL_MAX = 1'b0,
    POOL_AVG = 1'b1
  } pool_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } pool_state_e;

  // Clamp a wide signed value into the signed range of a narrower field.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                    input int width);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (width - 1));
    if (value > max_v) begin
      return max_v;
    end else if (value < min_v) begin
      return min_v;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/pool_lane.sv
// One pooling lane: accumulator (running max or running sum) plus the
// registered pooled result. Optional relu clamp under POOL_FUSED_RELU_EN.
module pool_lane
  import cnn_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int WIN_LOG2 = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_update,
  input  logic              i_finalize,
  input  logic              i_mode,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_result
);

  localparam int ACC_W = DATA_W + WIN_LOG2 + 1;

  pool_mode_e              w_mode;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_d_ext;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W-1:0] w_max;
  logic signed [ACC_W-1:0] w_acc_next;
  logic signed [ACC_W-1:0] w_shifted;
  logic signed [63:0]      w_shift_wide;
  logic signed [DATA_W-1:0] w_pooled;
  logic signed [DATA_W-1:0] w_result;
  logic [DATA_W-1:0]        r_result;

  assign w_mode  = pool_mode_e'(i_mode);
  assign w_d_ext = {{(ACC_W - DATA_W){i_data[DATA_W-1]}}, i_data};
  assign w_sum   = r_acc + w_d_ext;
  assign w_max   = (w_d_ext > r_acc) ? w_d_ext : r_acc;

  always_comb begin
    w_acc_next = r_acc;
    if (i_load) begin
      w_acc_next = w_d_ext;
    end else if (i_update) begin
      w_acc_next = (w_mode == POOL_AVG) ? w_sum : w_max;
    end
  end

  assign w_shifted    = w_acc_next >>> WIN_LOG2;
  assign w_shift_wide = {{(64 - ACC_W){w_shifted[ACC_W-1]}}, w_shifted};

  // A load that also finalizes is a single-element window: pass the sample through unshifted.
  always_comb begin
    if (i_load) begin
      w_pooled = $signed(i_data);
    end else if (w_mode == POOL_AVG) begin
      w_pooled = DATA_W'(sat_signed(w_shift_wide, DATA_W));
    end else begin
      w_pooled = w_acc_next[DATA_W-1:0];
    end
  end

`ifdef POOL_FUSED_RELU_EN
  assign w_result = w_pooled[DATA_W-1] ? '0 : w_pooled;
`else
  assign w_result = w_pooled;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_result <= '0;
    end else begin
      r_acc <= w_acc_next;
      if (i_finalize) begin
        r_result <= w_result;
      end
    end
  end

  assign o_result = r_result;

endmodule

// File: rtl/pool_stream.sv
// Streaming multi-lane max/avg pooling over s_first..s_last framed windows.
// Optional fused relu on the output when POOL_FUSED_RELU_EN is defined.
module pool_stream
  import cnn_pkg::*;
#(
  parameter int CHANNELS = 6,
  parameter int DATA_W   = 16,
  parameter int WIN_LOG2 = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_mode,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic                       s_first,
  input  logic                       s_last,
  input  logic [CHANNELS*DATA_W-1:0] s_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [CHANNELS*DATA_W-1:0] m_data,
  output logic                       err_frame
);

  localparam int              CNT_W   = WIN_LOG2 + 2;
  localparam logic [CNT_W-1:0] CNT_WIN = CNT_W'(2 ** WIN_LOG2);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(2 ** WIN_LOG2 + 1);

  pool_state_e      r_state;
  pool_mode_e       r_mode;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             r_m_valid;
  logic             r_err;
  logic             w_accept;
  logic             w_load;
  logic             w_update;
  logic             w_finalize;
  logic             w_lane_mode;

  // In HOLD the input only advances when the held result leaves in the same cycle.
  assign s_ready   = (r_state != HOLD) || m_ready;
  assign w_accept  = s_valid && s_ready;
  assign w_cnt_inc = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + 1'b1;

  always_comb begin
    w_load      = 1'b0;
    w_update    = 1'b0;
    w_finalize  = 1'b0;
    w_lane_mode = r_mode;
    if (w_accept) begin
      if (s_first) begin
        w_load      = 1'b1;
        w_lane_mode = cfg_mode;
        w_finalize  = s_last;
      end else if (r_state == ACCUM) begin
        w_update   = 1'b1;
        w_finalize = s_last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_mode    <= POOL_MAX;
      r_cnt     <= '0;
      r_m_valid <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_err <= 1'b0;
      unique case (r_state)
        IDLE, HOLD: begin
          if ((r_state == IDLE) || m_ready) begin
            r_m_valid <= 1'b0;
            r_state   <= IDLE;
            if (w_accept) begin
              if (s_first) begin
                r_mode    <= pool_mode_e'(cfg_mode);
                r_cnt     <= CNT_W'(1);
                r_state   <= s_last ? HOLD : ACCUM;
                r_m_valid <= s_last;
              end else begin
                r_err <= 1'b1;
              end
            end
          end
        end
        ACCUM: begin
          if (w_accept) begin
            if (s_first) begin
              r_err  <= 1'b1;
              r_mode <= pool_mode_e'(cfg_mode);
              r_cnt  <= CNT_W'(1);
              if (s_last) begin
                r_state   <= HOLD;
                r_m_valid <= 1'b1;
              end
            end else begin
              r_cnt <= w_cnt_inc;
              if (s_last) begin
                r_state   <= HOLD;
                r_m_valid <= 1'b1;
                if ((r_mode == POOL_AVG) && (w_cnt_inc != CNT_WIN)) begin
                  r_err <= 1'b1;
                end
              end
            end
          end
        end
        default: begin
          r_state   <= IDLE;
          r_m_valid <= 1'b0;
        end
      endcase
    end
  end

  assign m_valid   = r_m_valid;
  assign err_frame = r_err;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
      pool_lane #(
        .DATA_W  (DATA_W),
        .WIN_LOG2(WIN_LOG2)
      ) u_lane (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load),
        .i_update  (w_update),
        .i_finalize(w_finalize),
        .i_mode    (w_lane_mode),
        .i_data    (s_data[gi*DATA_W +: DATA_W]),
        .o_result  (m_data[gi*DATA_W +: DATA_W])
      );
    end
  endgenerate

endmodule

// File: tb/tb_pool_stream.sv
// Scoreboard bench for pool_stream: directed windows then random framed traffic,
// checked against a window-level reference model (honours POOL_FUSED_RELU_EN).
module tb_pool_stream;

  localparam int CH = 6;
  localparam int DW = 16;
  localparam int WL = 2;
  localparam int W  = CH * DW;

  logic         clk = 1'b0;
  logic         rst, cfg_mode, s_valid, s_ready, s_first, s_last;
  logic         m_valid, m_ready, err_frame;
  logic [W-1:0] s_data, m_data;

  pool_stream #(.CHANNELS(CH), .DATA_W(DW), .WIN_LOG2(WL)) dut (
    .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .s_valid(s_valid), .s_ready(s_ready),
    .s_first(s_first), .s_last(s_last), .s_data(s_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .err_frame(err_frame)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    int           cyc;
  } exp_t;

  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           n_results = 0;
  exp_t         res_q[$];
  bit           err_q[$];
  logic [W-1:0] win_q[$];
  logic [W-1:0] dir_q[$];
  bit           m_holding = 0;
  bit           m_in_win = 0;
  bit           m_avg = 0;

  function automatic longint floor_div(input longint s, input longint d);
    longint q;
    q = s / d;
    if ((q * d != s) && (s < 0)) q = q - 1;
    return q;
  endfunction

  // Pooled result of the window currently in win_q, straight from the arithmetic definition.
  function automatic logic [W-1:0] ref_result();
    logic [W-1:0] res;
    logic [W-1:0] beat;
    longint       v, acc, one, hi, lo;
    int           n;
    n   = win_q.size();
    one = 1;
    hi  = (one <<< (DW - 1)) - 1;
    lo  = -(one <<< (DW - 1));
    res = '0;
    for (int i = 0; i < CH; i++) begin
      acc = 0;
      for (int j = 0; j < n; j++) begin
        beat = win_q[j];
        v    = longint'($signed(beat[i*DW +: DW]));
        if (j == 0) acc = v;
        else if (m_avg) acc = acc + v;
        else if (v > acc) acc = v;
      end
      if (m_avg && n > 1) acc = floor_div(acc, one <<< WL);
      if (acc > hi) acc = hi;
      if (acc < lo) acc = lo;
`ifdef POOL_FUSED_RELU_EN
      if (acc < 0) acc = 0;
`endif
      res[i*DW +: DW] = DW'(acc);
    end
    return res;
  endfunction

  function automatic logic [W-1:0] rand_beat();
    logic [W-1:0]  b;
    logic [DW-1:0] x;
    for (int i = 0; i < CH; i++) begin
      x = DW'($urandom);
      if ($urandom_range(0, 7) == 0) x = {1'b0, {(DW-1){1'b1}}};
      else if ($urandom_range(0, 7) == 0) x = {1'b1, {(DW-1){1'b0}}};
      b[i*DW +: DW] = x;
    end
    return b;
  endfunction

  function automatic logic [W-1:0] make_beat(input int l0, input int l1);
    logic [W-1:0] b;
    b = rand_beat();
    b[0 +: DW]  = DW'(l0);
    b[DW +: DW] = DW'(l1);
    return b;
  endfunction

  function automatic logic [W-1:0] make_all(input int v);
    logic [W-1:0] b;
    for (int i = 0; i < CH; i++) b[i*DW +: DW] = DW'(v);
    return b;
  endfunction

  // One clock of stimulus; the reference model advances as if the rising edge just happened.
  task automatic step(input bit r, input bit v, input bit f, input bit l, input bit md,
                      input logic [W-1:0] d, input bit mr, output bit accepted);
    bit   exp_ready;
    bit   err;
    exp_t e;
    @(negedge clk);
    cyc++;
    rst = r; s_valid = v; s_first = f; s_last = l; cfg_mode = md; s_data = d; m_ready = mr;
    #1;
    exp_ready = !m_holding || mr;
    checks++;
    if (s_ready !== exp_ready) begin
      errors++;
      $display("FAIL s_ready cyc=%0d got=%b exp=%b", cyc, s_ready, exp_ready);
    end
    err      = 0;
    accepted = 0;
    if (r) begin
      m_holding = 0;
      m_in_win  = 0;
      win_q.delete();
    end else begin
      if (m_holding && mr) m_holding = 0;
      accepted = v && exp_ready;
      if (accepted) begin
        if (f) begin
          if (m_in_win) err = 1;
          win_q.delete();
          win_q.push_back(d);
          m_in_win = 1;
          m_avg    = md;
        end else if (m_in_win) begin
          win_q.push_back(d);
        end else begin
          err = 1;
        end
        if (m_in_win && l) begin
          e.data = ref_result();
          e.cyc  = cyc;
          res_q.push_back(e);
          if (m_avg && win_q.size() > 1 && win_q.size() != (1 << WL)) err = 1;
          m_holding = 1;
          m_in_win  = 0;
          win_q.delete();
        end
      end
    end
    err_q.push_back(err);
  endtask

  task automatic send_window(input bit md);
    bit acc;
    int n;
    n = dir_q.size();
    for (int k = 0; k < n; k++) begin
      step(0, 1, k == 0, k == n - 1, md, dir_q[k], 1, acc);
    end
    dir_q.delete();
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, rand_beat(), 1, acc);
  endtask

  // err_frame monitor: one expected flag per cycle, checked just after the edge.
  initial begin
    bit e;
    forever begin
      @(posedge clk);
      #1;
      if (err_q.size() > 0) begin
        e = err_q.pop_front();
        checks++;
        if (err_frame !== e) begin
          errors++;
          $display("FAIL err_frame cyc=%0d got=%b exp=%b", cyc, err_frame, e);
        end
      end
    end
  end

  // Result monitor: compares every held result, pops on handshake, enforces N+1 latency.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (m_valid === 1'b1) begin
        checks++;
        if (res_q.size() == 0) begin
          errors++;
          $display("FAIL m_valid_unexpected cyc=%0d got=%h exp=none", cyc, m_data);
        end else begin
          if (m_data !== res_q[0].data) begin
            errors++;
            $display("FAIL m_data cyc=%0d got=%h exp=%h", cyc, m_data, res_q[0].data);
          end
          if (m_ready) begin
            n_results++;
            $display("result %0d cyc=%0d data=%h", n_results, cyc, m_data);
            void'(res_q.pop_front());
          end
        end
      end else if (res_q.size() > 0 && cyc > res_q[0].cyc) begin
        checks++;
        errors++;
        $display("FAIL m_valid_latency cyc=%0d got=%b exp=1", cyc, m_valid);
      end
    end
  end

  initial begin
    bit           acc;
    bit           v, f, l, md, mr, r;
    int           pos, len;
    logic [W-1:0] nb;

    rst = 1; s_valid = 0; s_first = 0; s_last = 0; cfg_mode = 0; s_data = '0; m_ready = 0;
    for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 0, '0, 0, acc);
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0 || err_frame !== 1'b0 || m_data !== '0) begin
      errors++;
      $display("FAIL reset_state got=%b%b%b/%h exp=100/0", s_ready, m_valid, err_frame, m_data);
    end

    // max window, lane0 -> 12, lane1 -> -1
    dir_q = '{make_beat(3, -1), make_beat(-7, -2), make_beat(12, -3), make_beat(5, -4)};
    send_window(0);
    idle(2);
    // avg windows: 46>>>2 = 11 and floor(-5/4) = -2
    dir_q = '{make_beat(10, -1), make_beat(11, -1), make_beat(12, -1), make_beat(13, -2)};
    send_window(1);
    idle(1);
    // avg saturation corners
    dir_q = '{make_all(32767), make_all(32767), make_all(32767), make_all(32767)};
    send_window(1);
    dir_q = '{make_all(-32768), make_all(-32768), make_all(-32768), make_all(-32768)};
    send_window(1);
    idle(2);

    // stall in HOLD for 5 cycles, then both handshakes in one cycle, then zero-bubble follow-up
    dir_q = '{rand_beat(), rand_beat(), rand_beat(), rand_beat()};
    send_window(0);
    nb = make_beat(1, 2);
    for (int k = 0; k < 5; k++) step(0, 1, 1, 0, 1, nb, 0, acc);
    step(0, 1, 1, 0, 1, nb, 1, acc);
    step(0, 1, 0, 0, 0, rand_beat(), 1, acc);
    step(0, 1, 0, 0, 0, rand_beat(), 1, acc);
    step(0, 1, 0, 1, 0, rand_beat(), 1, acc);
    dir_q = '{rand_beat(), rand_beat()};
    send_window(0);
    idle(2);

    // framing: stray beats in IDLE, restart mid-window, short avg window
    step(0, 1, 0, 0, 0, rand_beat(), 1, acc);
    step(0, 1, 0, 1, 0, rand_beat(), 1, acc);
    idle(1);
    step(0, 1, 1, 0, 1, make_beat(1000, 1000), 1, acc);
    step(0, 1, 0, 0, 1, make_beat(1000, 1000), 1, acc);
    dir_q = '{make_beat(4, -4), make_beat(8, -8), make_beat(12, -12), make_beat(16, -16)};
    send_window(1);
    dir_q = '{make_beat(3, 3), make_beat(6, 6), make_beat(9, 9)};
    send_window(1);
    idle(1);
    // single-element windows
    dir_q = '{make_beat(-77, 77)};
    send_window(1);
    dir_q = '{make_beat(-9, 9)};
    send_window(0);
    idle(1);

    // reset during beat 2 discards the partial window
    step(0, 1, 1, 0, 1, rand_beat(), 1, acc);
    step(1, 1, 0, 0, 1, rand_beat(), 1, acc);
    step(1, 0, 0, 0, 0, rand_beat(), 1, acc);
    dir_q = '{rand_beat(), rand_beat(), rand_beat(), rand_beat()};
    send_window(1);
    // negative max (clamped to 0 with fused relu)
    dir_q = '{make_beat(-5, -5), make_beat(-3, -3)};
    send_window(0);
    idle(2);

    // random framed traffic with stalls, framing faults and occasional resets
    pos = 0;
    len = 4;
    for (int i = 0; i < 2500; i++) begin
      v  = ($urandom_range(0, 9) < 8);
      f  = (pos == 0);
      if ($urandom_range(0, 29) == 0) f = !f;
      l  = (pos == len - 1);
      md = 1'($urandom_range(0, 1));
      mr = ($urandom_range(0, 9) < 7);
      r  = !m_holding && ($urandom_range(0, 199) == 0);
      step(r, v, f, l, md, rand_beat(), mr, acc);
      if (r) begin
        pos = 0;
      end else if (acc) begin
        if (pos == len - 1) begin
          pos = 0;
          len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 4;
        end else begin
          pos++;
        end
      end
    end

    idle(10);
    checks++;
    if (res_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending exp=0", res_q.size());
    end
    #20;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
